// File: rtl/dca_lsu_arb_pkg.sv
// Shared types and widths for the two-requester LSU/XMI arbiter: FSM state encoding,
// outstanding-counter width and grant-statistics width.
package dca_lsu_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } arb_state_e;

    localparam int unsigned OutstW = 4;
    localparam int unsigned StatW  = 16;

endpackage

// File: rtl/dca_lsu_arb_outstanding_cnt.sv
// Saturating up/down counter of unanswered transactions with a full flag at MaxCount.
// A simultaneous increment and decrement leaves the count unchanged.
module dca_lsu_arb_outstanding_cnt
    import dca_lsu_arb_pkg::*;
#(
    parameter int unsigned MaxCount = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [OutstW-1:0] cnt_o,
    output logic              full_o
);

    localparam logic [OutstW-1:0] MaxCnt = OutstW'(MaxCount);

    logic [OutstW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q < MaxCnt)) begin
            cnt_d = cnt_q + OutstW'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - OutstW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q >= MaxCnt);

endmodule

// File: rtl/dca_matrix_lsu_xmi_arb.sv
// Two-requester round-robin burst arbiter onto one XMI master port, with burden-tagged response
// routing. Define DCA_MATRIX_LSU_ARB_STAT_EN to add saturating per-requester grant counters.
module dca_matrix_lsu_xmi_arb
    import dca_lsu_arb_pkg::*;
#(
    parameter int unsigned BW_ADDR         = 32,
    parameter int unsigned BW_DATA         = 32,
    parameter int unsigned BW_BURDEN       = 1,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   r0_qvalid,
    input  logic                   r0_qlast,
    input  logic                   r0_qwrite,
    input  logic [7:0]             r0_qlen,
    input  logic [BW_ADDR-1:0]     r0_qaddr,
    input  logic [BW_DATA-1:0]     r0_qwdata,
    input  logic [BW_DATA/8-1:0]   r0_qwstrb,
    input  logic [BW_BURDEN-1:0]   r0_qburden,
    output logic                   r0_qready,
    output logic                   r0_yvalid,
    output logic                   r0_ylast,
    output logic                   r0_ywreply,
    output logic [1:0]             r0_yresp,
    output logic [BW_DATA-1:0]     r0_yrdata,
    output logic [BW_BURDEN-1:0]   r0_yburden,
    input  logic                   r0_yready,

    input  logic                   r1_qvalid,
    input  logic                   r1_qlast,
    input  logic                   r1_qwrite,
    input  logic [7:0]             r1_qlen,
    input  logic [BW_ADDR-1:0]     r1_qaddr,
    input  logic [BW_DATA-1:0]     r1_qwdata,
    input  logic [BW_DATA/8-1:0]   r1_qwstrb,
    input  logic [BW_BURDEN-1:0]   r1_qburden,
    output logic                   r1_qready,
    output logic                   r1_yvalid,
    output logic                   r1_ylast,
    output logic                   r1_ywreply,
    output logic [1:0]             r1_yresp,
    output logic [BW_DATA-1:0]     r1_yrdata,
    output logic [BW_BURDEN-1:0]   r1_yburden,
    input  logic                   r1_yready,

    output logic                   mq_valid,
    output logic                   mq_last,
    output logic                   mq_write,
    output logic [7:0]             mq_len,
    output logic [BW_ADDR-1:0]     mq_addr,
    output logic [BW_DATA-1:0]     mq_wdata,
    output logic [BW_DATA/8-1:0]   mq_wstrb,
    output logic [BW_BURDEN:0]     mq_burden,
    input  logic                   mq_ready,

    input  logic                   my_valid,
    input  logic                   my_last,
    input  logic                   my_wreply,
    input  logic [1:0]             my_resp,
    input  logic [BW_DATA-1:0]     my_rdata,
    input  logic [BW_BURDEN:0]     my_burden,
    output logic                   my_ready,

`ifdef DCA_MATRIX_LSU_ARB_STAT_EN
    output logic [StatW-1:0]       stat_grant0,
    output logic [StatW-1:0]       stat_grant1,
`endif
    output logic                   busy
);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic              locked;
    logic              owner;
    logic              burst_done;
    logic              rsp_sel;
    logic              rsp_done;
    logic [OutstW-1:0] outs_cnt;
    logic              outs_full;

    assign locked = (state_q == StLock0) || (state_q == StLock1);
    assign owner  = (state_q == StLock1);

    // Request path: the locked requester drives the master port; nothing is issued while idle.
    always_comb begin
        if (owner) begin
            mq_last   = r1_qlast;
            mq_write  = r1_qwrite;
            mq_len    = r1_qlen;
            mq_addr   = r1_qaddr;
            mq_wdata  = r1_qwdata;
            mq_wstrb  = r1_qwstrb;
            mq_burden = {1'b1, r1_qburden};
        end else begin
            mq_last   = r0_qlast;
            mq_write  = r0_qwrite;
            mq_len    = r0_qlen;
            mq_addr   = r0_qaddr;
            mq_wdata  = r0_qwdata;
            mq_wstrb  = r0_qwstrb;
            mq_burden = {1'b0, r0_qburden};
        end
    end

    assign mq_valid   = locked && (owner ? r1_qvalid : r0_qvalid);
    assign r0_qready  = (state_q == StLock0) && mq_ready;
    assign r1_qready  = (state_q == StLock1) && mq_ready;
    assign burst_done = mq_valid && mq_ready && mq_last;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if ((r0_qvalid || r1_qvalid) && !outs_full) begin
                    if (r0_qvalid && r1_qvalid) begin
                        state_d = rr_q ? StLock1 : StLock0;
                    end else begin
                        state_d = r1_qvalid ? StLock1 : StLock0;
                    end
                end
            end
            StLock0, StLock1: begin
                // Only a last-beat handshake releases the lock; a qvalid drop just stalls.
                if (burst_done) begin
                    rr_d    = ~owner;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Response path: the burden MSB names the requester, independent of the request FSM.
    assign rsp_sel    = my_burden[BW_BURDEN];
    assign r0_yvalid  = my_valid && !rsp_sel;
    assign r1_yvalid  = my_valid && rsp_sel;
    assign r0_ylast   = my_last;
    assign r1_ylast   = my_last;
    assign r0_ywreply = my_wreply;
    assign r1_ywreply = my_wreply;
    assign r0_yresp   = my_resp;
    assign r1_yresp   = my_resp;
    assign r0_yrdata  = my_rdata;
    assign r1_yrdata  = my_rdata;
    assign r0_yburden = my_burden[BW_BURDEN-1:0];
    assign r1_yburden = my_burden[BW_BURDEN-1:0];
    assign my_ready   = rsp_sel ? r1_yready : r0_yready;
    assign rsp_done   = my_valid && my_ready && my_last;

    dca_lsu_arb_outstanding_cnt #(
        .MaxCount(MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (burst_done),
        .dec_i (rsp_done),
        .cnt_o (outs_cnt),
        .full_o(outs_full)
    );

    assign busy = (state_q != StIdle) || (outs_cnt != '0) || r0_qvalid || r1_qvalid;

`ifdef DCA_MATRIX_LSU_ARB_STAT_EN
    logic [StatW-1:0] stat0_q, stat0_d;
    logic [StatW-1:0] stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (burst_done && !owner && (stat0_q != '1)) begin
            stat0_d = stat0_q + StatW'(1);
        end
        if (burst_done && owner && (stat1_q != '1)) begin
            stat1_d = stat1_q + StatW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat_grant0 = stat0_q;
    assign stat_grant1 = stat1_q;
`endif

endmodule
